// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues sequential word fetches and
// buffers returned words with their PCs for the decoder; redirects flush and squash.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);

  logic [31:0]   r_fetchPc;
  logic [31:0]   r_qInstr [DEPTH];
  logic [31:0]   r_qPc    [DEPTH];
  logic [31:0]   r_pcFifo [DEPTH];
  logic [AW-1:0] r_rdPtr;
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_pfRdPtr;
  logic [AW-1:0] r_pfWrPtr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;

  logic [CW:0]   w_credit;
  logic          w_issue;
  logic          w_ret;
  logic          w_push;
  logic          w_pop;

  // Credit covers both buffered words and words still in flight, so a grant never overflows.
  assign w_credit    = {1'b0, r_count} + {1'b0, r_outstanding};
  assign imem_req    = (w_credit < CREDIT_MAX) && !redirect;
  assign imem_addr   = r_fetchPc;
  assign w_issue     = imem_req && imem_gnt;
  assign w_ret       = imem_rvalid && (r_outstanding != '0);
  assign w_push      = w_ret && (r_drop == '0) && !redirect;
  assign instr_valid = (r_count != '0);
  assign w_pop       = instr_valid && instr_ready && !redirect;
  assign instr       = r_qInstr[r_rdPtr];
  assign instr_pc    = r_qPc[r_rdPtr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetchPc     <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_rdPtr       <= '0;
      r_wrPtr       <= '0;
      r_pfRdPtr     <= '0;
      r_pfWrPtr     <= '0;
    end else if (redirect) begin
      // Every fetch still in flight after this cycle belongs to the old path.
      r_fetchPc     <= redirect_pc & 32'hFFFF_FFFC;
      r_count       <= '0;
      r_rdPtr       <= '0;
      r_wrPtr       <= '0;
      r_outstanding <= r_outstanding - CW'(w_ret);
      r_drop        <= r_outstanding - CW'(w_ret);
      r_pfRdPtr     <= r_pfWrPtr;
    end else begin
      if (w_issue) begin
        r_fetchPc <= r_fetchPc + 32'd4;
        r_pfWrPtr <= r_pfWrPtr + AW'(1);
      end
      if (w_ret && (r_drop != '0)) begin
        r_drop <= r_drop - CW'(1);
      end
      if (w_push) begin
        r_wrPtr   <= r_wrPtr + AW'(1);
        r_pfRdPtr <= r_pfRdPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_ret);
      r_count       <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Dropped responses never reach the pc FIFO, so it only tracks fetches that will be kept.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_pcFifo[r_pfWrPtr] <= r_fetchPc;
    end
    if (w_push) begin
      r_qInstr[r_wrPtr] <= imem_rdata;
      r_qPc[r_wrPtr]    <= r_pcFifo[r_pfRdPtr];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every cycle, an in-order
// memory responder, and directed scenarios with hand-computed expectations.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] PATTERN = 32'hA5A5_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic        drop;
  } flight_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  int errors = 0;
  int checks = 0;

  flight_t     mFlight[$];
  entry_t      mQueue[$];
  logic [31:0] mFetchPc;
  logic [31:0] memPending[$];
  logic        expReq;
  flight_t     retFlight;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Compare outputs against the model, then advance the model to the next clock edge.
  always @(negedge clk) begin
    if (rst) begin
      mFlight.delete();
      mQueue.delete();
      memPending.delete();
      mFetchPc = 32'h0;
    end else begin
      expReq = ((mQueue.size() + mFlight.size()) < DEPTH) && !redirect;
      checkOutput("imem_req", {31'b0, imem_req}, {31'b0, expReq});
      checkOutput("imem_addr", imem_addr, mFetchPc);
      checkOutput("instr_valid", {31'b0, instr_valid}, 32'(mQueue.size() > 0));
      if (mQueue.size() > 0) begin
        checkOutput("instr", instr, mQueue[0].instr);
        checkOutput("instr_pc", instr_pc, mQueue[0].pc);
      end
      if (imem_req && imem_gnt) memPending.push_back(imem_addr);
      if (imem_rvalid) checkOutput("outstanding_on_rvalid", 32'(mFlight.size() > 0), 32'd1);
      if (redirect) begin
        if (imem_rvalid && (mFlight.size() > 0)) void'(mFlight.pop_front());
        foreach (mFlight[i]) mFlight[i].drop = 1'b1;
        mQueue.delete();
        mFetchPc = {redirect_pc[31:2], 2'b00};
      end else begin
        if ((mQueue.size() > 0) && instr_ready) void'(mQueue.pop_front());
        if (imem_rvalid && (mFlight.size() > 0)) begin
          retFlight = mFlight.pop_front();
          if (!retFlight.drop) mQueue.push_back('{instr: imem_rdata, pc: retFlight.pc});
        end
        if (expReq && imem_gnt) begin
          mFlight.push_back('{pc: mFetchPc, drop: 1'b0});
          mFetchPc = mFetchPc + 32'd4;
        end
      end
    end
  end

  // One cycle: drive inputs just after the edge, return at the following falling edge.
  task automatic applyStimulus(input logic rstV, input logic gntV, input logic rvV,
                               input logic readyV, input logic redirV, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst         = rstV;
    imem_gnt    = gntV;
    instr_ready = readyV;
    redirect    = redirV;
    redirect_pc = rpc;
    if (rvV && !rstV && (memPending.size() > 0)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memPending.pop_front() ^ PATTERN;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    @(negedge clk);
  endtask

  task automatic resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] rpc;

    $display("[TB] reset state");
    resetDut();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("reset_req", {31'b0, imem_req}, 32'd1);
    checkOutput("reset_addr", imem_addr, 32'h0);
    checkOutput("reset_valid", {31'b0, instr_valid}, 32'd0);

    $display("[TB] streaming one instruction per cycle");
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (k >= 2) begin
        checkOutput("stream_valid", {31'b0, instr_valid}, 32'd1);
        checkOutput("stream_pc", instr_pc, 32'(4 * (k - 2)));
        checkOutput("stream_instr", instr, 32'(4 * (k - 2)) ^ PATTERN);
      end
    end

    $display("[TB] full queue backpressure");
    resetDut();
    for (int k = 0; k < 7; k++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("full_req", {31'b0, imem_req}, 32'd0);
    checkOutput("full_addr", imem_addr, 32'h10);
    checkOutput("full_head_pc", instr_pc, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("pop_cycle_req", {31'b0, imem_req}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("after_pop_req", {31'b0, imem_req}, 32'd1);
    checkOutput("after_pop_addr", imem_addr, 32'h10);
    checkOutput("after_pop_pc", instr_pc, 32'h4);

    $display("[TB] redirect with two fetches outstanding");
    resetDut();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
    checkOutput("redir_req", {31'b0, imem_req}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("redir_new_req", {31'b0, imem_req}, 32'd1);
    checkOutput("redir_new_addr", imem_addr, 32'h100);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("drop_valid", {31'b0, instr_valid}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("redir_head_pc", instr_pc, 32'h100);
    checkOutput("redir_head_instr", instr, 32'hA5A5_0100);

    $display("[TB] redirect colliding with response and pop");
    resetDut();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
    checkOutput("collide_valid", {31'b0, instr_valid}, 32'd1);
    checkOutput("collide_pc", instr_pc, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("collide_empty", {31'b0, instr_valid}, 32'd0);
    checkOutput("collide_addr", imem_addr, 32'h200);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("collide_head_pc", instr_pc, 32'h200);

    $display("[TB] address wrap and random stalls");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("wrap_addr_hi", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("wrap_addr_lo", imem_addr, 32'h0);
    for (int k = 0; k < 600; k++) begin
      if (k == 300) resetDut();
      rpc = ($urandom_range(0, 1) != 0) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
      applyStimulus(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, rpc);
    end
    for (int k = 0; k < 20; k++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("drain_empty", {31'b0, instr_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
